// File: rtl/spi_slave_interface_pkg.sv
// Shared SPI definitions: byte width, clock mode and the peripheral FSM states.
// Pure declarations, no latency; no flow control.
package spi_slave_interface_pkg;

   localparam int SPI_BYTE_W = 8;
   localparam int SPI_CPOL   = 1;
   localparam int SPI_CPHA   = 1;
   localparam int SPI_CNT_W  = $clog2(SPI_BYTE_W);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SHIFT     = 2'd1,
      BYTE_DONE = 2'd2
   } spi_slv_state_t;

   function automatic logic [SPI_BYTE_W-1:0] spi_shift_in(
      input logic [SPI_BYTE_W-1:0] cur,
      input logic                  din
   );
      return {cur[SPI_BYTE_W-2:0], din};
   endfunction

endpackage

// File: rtl/spi_slave_interface_if.sv
// SPI pins plus fabric-side byte handshake of the peripheral endpoint.
// Wiring only, no latency; tx side uses load/tx_ready, rx side is a valid strobe without backpressure.
interface spi_slave_interface_if;
   import spi_slave_interface_pkg::*;

   logic                  sclk;
   logic                  slave_select;
   logic                  mosi;
   logic                  miso;
   logic                  miso_oe;
   logic [SPI_BYTE_W-1:0] send_data;
   logic                  load;
   logic                  tx_ready;
   logic [SPI_BYTE_W-1:0] recieved_data;
   logic                  rx_valid;
   logic                  busy;
   logic                  tx_underrun;
   logic                  frame_abort;

   modport slave (
      input  sclk, slave_select, mosi, send_data, load,
      output miso, miso_oe, tx_ready, recieved_data, rx_valid, busy, tx_underrun, frame_abort
   );

   modport master (
      output sclk, slave_select, mosi, send_data, load,
      input  miso, miso_oe, tx_ready, recieved_data, rx_valid, busy, tx_underrun, frame_abort
   );
endinterface

// File: rtl/spi_slave_interface_edge_sync.sv
// Multi-flop synchronizer with rise/fall detect on the synchronized level.
// Latency: STAGES clk to level_o, edge pulses valid alongside; no backpressure.
module spi_slave_interface_edge_sync #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= {STAGES{INIT}};
         prev_q <= INIT;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = ~prev_q &  sync_q[STAGES-1];
   assign fall_o  =  prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_interface.sv
// SPI mode-3 peripheral: oversampled byte transfers, MSB first, rx strobe and tx holding register.
// rx_valid follows the 8th sclk rise by SYNC_STAGES+2 clk; tx accepts a byte only while tx_ready.
module spi_slave_interface
   import spi_slave_interface_pkg::*;
#(
   parameter int                    SYNC_STAGES = 2,
   parameter logic [SPI_BYTE_W-1:0] DEFAULT_TX  = 8'hFF
) (
   input logic                   clk,
   input logic                   rst,
   spi_slave_interface_if.slave  spi
);

   localparam logic                 SCLK_IDLE      = (SPI_CPOL != 0);
   localparam logic                 LAUNCH_ON_FALL = (SPI_CPOL == SPI_CPHA);
   localparam logic [SPI_CNT_W-1:0] CNT_MAX        = SPI_CNT_W'(SPI_BYTE_W - 1);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic ss_lvl, ss_rise, ss_fall;
   logic mosi_s, ss_active, launch, sample, mid_bit;
   logic [SYNC_STAGES-1:0] mosi_sync_q;

   spi_slave_interface_edge_sync #(.STAGES(SYNC_STAGES), .INIT(SCLK_IDLE)) u_sclk_sync (
      .clk     (clk),
      .rst     (rst),
      .din_i   (spi.sclk),
      .level_o (sclk_lvl),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall)
   );

   spi_slave_interface_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss_sync (
      .clk     (clk),
      .rst     (rst),
      .din_i   (spi.slave_select),
      .level_o (ss_lvl),
      .rise_o  (ss_rise),
      .fall_o  (ss_fall)
   );

   // mosi gets the same depth as sclk so data and its sampling edge stay aligned
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) mosi_sync_q <= '1;
      else      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
   end

   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign ss_active = ~ss_lvl;
   assign launch    = LAUNCH_ON_FALL ? sclk_fall : sclk_rise;
   assign sample    = LAUNCH_ON_FALL ? sclk_rise : sclk_fall;
   assign mid_bit   = (sclk_lvl != SCLK_IDLE);

   spi_slv_state_t        state_q, state_d;
   logic [SPI_BYTE_W-1:0] shift_q, shift_d;
   logic [SPI_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic                  miso_q, miso_d;
   logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  underrun_q, underrun_d;
   logic                  abort_q, abort_d;
   logic [SPI_BYTE_W-1:0] hold_q, hold_d;
   logic                  hold_full_q, hold_full_d;
   logic                  reload, capture;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         miso_q      <= 1'b1;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         abort_q     <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         miso_q      <= miso_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
         abort_q     <= abort_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      miso_d     = miso_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      underrun_d = 1'b0;
      abort_d    = 1'b0;
      reload     = 1'b0;

      case (state_q)
         IDLE: begin
            miso_d    = 1'b1;
            bit_cnt_d = '0;
            if (ss_fall) begin
               reload  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // deselect outranks a same-cycle sample edge; a half-clocked bit counts as partial
            if (ss_rise) begin
               state_d = IDLE;
               miso_d  = 1'b1;
               abort_d = (bit_cnt_q != '0) || mid_bit || sample;
            end else begin
               if (launch) miso_d = shift_q[SPI_BYTE_W-1];
               if (sample) begin
                  shift_d   = spi_shift_in(shift_q, mosi_s);
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == CNT_MAX) begin
                     rx_data_d = spi_shift_in(shift_q, mosi_s);
                     state_d   = BYTE_DONE;
                  end
               end
            end
         end
         BYTE_DONE: begin
            rx_valid_d = 1'b1;
            if (ss_active) begin
               reload  = 1'b1;
               state_d = SHIFT;
            end else begin
               miso_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (reload) begin
         shift_d    = hold_full_q ? hold_q : DEFAULT_TX;
         underrun_d = ~hold_full_q;
         bit_cnt_d  = '0;
      end

      // a load racing the reload still lands: the reload already took the old byte
      capture     = spi.load && (!hold_full_q || reload);
      hold_d      = capture ? spi.send_data : hold_q;
      hold_full_d = capture ? 1'b1 : (reload ? 1'b0 : hold_full_q);
   end

   assign spi.miso          = miso_q;
   assign spi.miso_oe       = (state_q != IDLE);
   assign spi.busy          = (state_q == SHIFT);
   assign spi.tx_ready      = ~hold_full_q;
   assign spi.recieved_data = rx_data_q;
   assign spi.rx_valid      = rx_valid_q;
   assign spi.tx_underrun   = underrun_q;
   assign spi.frame_abort   = abort_q;

endmodule

// File: tb/tb_spi_slave_interface.sv
// Directed bench: mode-3 master model with sclk = clk/8 and a transaction-level model of the tx/rx path.
module tb_spi_slave_interface;

   localparam int         SYNC   = 2;
   localparam logic [7:0] DEF_TX = 8'hFF;

   logic clk = 1'b0;
   logic rst = 1'b0;

   spi_slave_interface_if sif();

   spi_slave_interface #(.SYNC_STAGES(SYNC), .DEFAULT_TX(DEF_TX)) dut (
      .clk (clk),
      .rst (rst),
      .spi (sif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_hold = 8'h00;
   bit         m_full = 1'b0;
   logic [7:0] rxq[$];
   int und_exp = 0, und_seen = 0, abt_exp = 0, abt_seen = 0;
   int cyc = 0, last_rise_cyc = 0;
   logic rx_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst) begin
         if (sif.rx_valid) begin
            logic [7:0] exp_b;
            check("rx_single_cycle", {31'd0, rx_prev}, 32'd0);
            check("rx_expected", {31'd0, rxq.size() > 0}, 32'd1);
            if (rxq.size() > 0) begin
               exp_b = rxq.pop_front();
               check("rx_data", {24'd0, sif.recieved_data}, {24'd0, exp_b});
            end
            check("rx_latency", cyc - last_rise_cyc, SYNC + 2);
         end
         if (sif.tx_underrun) und_seen++;
         if (sif.frame_abort) abt_seen++;
         if (sif.busy) check("oe_while_busy", {31'd0, sif.miso_oe}, 32'd1);
      end
      rx_prev = sif.rx_valid;
   end

   task automatic load_byte(input logic [7:0] d);
      sif.send_data = d;
      sif.load      = 1'b1;
      @(negedge clk);
      sif.load      = 1'b0;
      if (!m_full) begin
         m_hold = d;
         m_full = 1'b1;
      end
   endtask

   task automatic frame_start();
      sif.slave_select = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic frame_end();
      sif.slave_select = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Returns 1 clk after the last rising edge; back-to-back callers wait 3 more clk.
   task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      logic [7:0] exp_mi;
      exp_mi = m_full ? m_hold : DEF_TX;
      if (!m_full) und_exp++;
      m_full = 1'b0;
      mi = 8'h00;
      for (int i = 7; i >= 8 - nbits; i--) begin
         sif.sclk = 1'b0;
         sif.mosi = mo[i];
         repeat (4) @(negedge clk);
         mi[i] = sif.miso;
         sif.sclk = 1'b1;
         last_rise_cyc = cyc;
         repeat ((i == 8 - nbits) ? 1 : 4) @(negedge clk);
      end
      if (nbits == 8) begin
         rxq.push_back(mo);
         check("miso_byte_model", {24'd0, mi}, {24'd0, exp_mi});
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"},     {31'd0, sif.miso},          32'd1);
      check({tag, "_miso_oe"},  {31'd0, sif.miso_oe},       32'd0);
      check({tag, "_rx_data"},  {24'd0, sif.recieved_data}, 32'd0);
      check({tag, "_rx_valid"}, {31'd0, sif.rx_valid},      32'd0);
      check({tag, "_tx_ready"}, {31'd0, sif.tx_ready},      32'd1);
      check({tag, "_busy"},     {31'd0, sif.busy},          32'd0);
      check({tag, "_underrun"}, {31'd0, sif.tx_underrun},   32'd0);
      check({tag, "_abort"},    {31'd0, sif.frame_abort},   32'd0);
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_underruns"}, und_seen, und_exp);
      check({tag, "_aborts"},    abt_seen, abt_exp);
      check({tag, "_rx_pending"}, rxq.size(), 0);
   endtask

   initial begin
      logic [7:0] mi, mi2;
      sif.sclk = 1'b1;
      sif.slave_select = 1'b1;
      sif.mosi = 1'b1;
      sif.send_data = 8'h00;
      sif.load = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // 1: loaded response, single byte
      load_byte(8'hA5);
      check("t1_tx_ready_loaded", {31'd0, sif.tx_ready}, 32'd0);
      frame_start();
      check("t1_tx_ready_after_select", {31'd0, sif.tx_ready}, 32'd1);
      xfer(8'h3C, 8, mi);
      frame_end();
      check("t1_miso", {24'd0, mi}, 32'hA5);
      check("t1_rx", {24'd0, sif.recieved_data}, 32'h3C);
      check("t1_oe_idle", {31'd0, sif.miso_oe}, 32'd0);
      check_counts("t1");

      // 2: no load -> default byte and underrun
      frame_start();
      xfer(8'h00, 8, mi);
      frame_end();
      check("t2_miso", {24'd0, mi}, 32'hFF);
      check("t2_underruns", und_seen, 1);
      check_counts("t2");

      // 3: two bytes under one select, second response loaded while busy
      load_byte(8'h11);
      frame_start();
      fork
         xfer(8'hC3, 8, mi);
         begin
            repeat (30) @(negedge clk);
            load_byte(8'h22);
            check("t3_tx_ready_busy_load", {31'd0, sif.tx_ready}, 32'd0);
         end
      join
      repeat (3) @(negedge clk);
      xfer(8'h5A, 8, mi2);
      frame_end();
      check("t3_miso0", {24'd0, mi}, 32'h11);
      check("t3_miso1", {24'd0, mi2}, 32'h22);
      check("t3_rx", {24'd0, sif.recieved_data}, 32'h5A);
      check_counts("t3");

      // 4: abort after 5 rising edges, then a clean byte
      frame_start();
      xfer(8'hF0, 5, mi);
      abt_exp++;
      frame_end();
      check("t4_oe_after_abort", {31'd0, sif.miso_oe}, 32'd0);
      check("t4_aborts", abt_seen, 1);
      frame_start();
      xfer(8'h81, 8, mi);
      frame_end();
      check("t4_rx", {24'd0, sif.recieved_data}, 32'h81);
      check("t4_miso", {24'd0, mi}, 32'hFF);
      check_counts("t4");

      // 5: async reset during bit 3
      load_byte(8'h96);
      frame_start();
      xfer(8'hA5, 3, mi);
      rst = 1'b0;
      #1;
      check_reset_outputs("t5_reset");
      m_full = 1'b0;
      rxq.delete();
      sif.slave_select = 1'b1;
      sif.sclk = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      load_byte(8'h69);
      frame_start();
      xfer(8'h96, 8, mi);
      frame_end();
      check("t5_miso", {24'd0, mi}, 32'h69);
      check("t5_rx", {24'd0, sif.recieved_data}, 32'h96);
      check_counts("t5");

      // 6: load while full is ignored
      load_byte(8'h77);
      load_byte(8'hEE);
      check("t6_tx_ready", {31'd0, sif.tx_ready}, 32'd0);
      frame_start();
      xfer(8'h01, 8, mi);
      frame_end();
      frame_start();
      xfer(8'h02, 8, mi2);
      frame_end();
      check("t6_miso_held", {24'd0, mi}, 32'h77);
      check("t6_miso_next", {24'd0, mi2}, 32'hFF);
      check("t6_rx", {24'd0, sif.recieved_data}, 32'h02);
      check_counts("t6");
      check("total_underruns", und_seen, 4);
      check("total_aborts", abt_seen, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
